// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: sequencer states and the
// per-pipeline-register stall/flush control bundle.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    MD_BUSY,
    MD_HOLD
  } hz_state_e;

  // Bit positions inside hz_ctrl_t.stall / hz_ctrl_t.flush
  localparam int ST_IF  = 0;
  localparam int ST_ID  = 1;
  localparam int ST_EX  = 2;
  localparam int ST_MEM = 3;
  localparam int FL_ID  = 0;
  localparam int FL_EX  = 1;
  localparam int FL_MEM = 2;
  localparam int FL_WB  = 3;

  typedef struct packed {
    logic [3:0] stall;
    logic [3:0] flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_NOP = '{stall: 4'b0000, flush: 4'b0000};

  function automatic hz_ctrl_t hz_make(logic [3:0] stall, logic [3:0] flush);
    hz_ctrl_t c;
    c.stall = stall;
    c.flush = flush;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus between the pipeline datapath (master) and the controller (slave).
// Perf counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
);

  logic [REG_AW-1:0] ID_rs1;
  logic [REG_AW-1:0] ID_rs2;
  logic              ID_use_rs1;
  logic              ID_use_rs2;
  logic [REG_AW-1:0] EX_rd;
  logic              EX_mem_read;
  logic              EX_pc_src;
  logic              EX_muldiv;
  logic              muldiv_done;
  logic              MEM_access;
  logic              dmem_ready;
  logic              muldiv_start;
  logic              muldiv_abort;
  logic              IF_stall;
  logic              ID_stall;
  logic              EX_stall;
  logic              MEM_stall;
  logic              ID_flush;
  logic              EX_flush;
  logic              MEM_flush;
  logic              WB_flush;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]  perf_stall_cnt;
  logic [CNT_W-1:0]  perf_flush_cnt;
`endif

  modport master (
    output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_mem_read,
           EX_pc_src, EX_muldiv, muldiv_done, MEM_access, dmem_ready,
    input  muldiv_start, muldiv_abort, IF_stall, ID_stall, EX_stall, MEM_stall,
           ID_flush, EX_flush, MEM_flush, WB_flush
`ifdef HAZARD_PERF_CNT_EN
    , input perf_stall_cnt, perf_flush_cnt
`endif
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_mem_read,
           EX_pc_src, EX_muldiv, muldiv_done, MEM_access, dmem_ready,
    output muldiv_start, muldiv_abort, IF_stall, ID_stall, EX_stall, MEM_stall,
           ID_flush, EX_flush, MEM_flush, WB_flush
`ifdef HAZARD_PERF_CNT_EN
    , output perf_stall_cnt, perf_flush_cnt
`endif
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_muldiv_seq.sv
// Mul/div occupancy sequencer: start handshake, timeout counter and the
// done_seen latch that remembers a result arriving during a memory wait.
module pipeline_hazard_ctrl_muldiv_seq
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ex_muldiv,
  input  logic muldiv_done,
  input  logic mem_wait,
  output logic md_active,
  output logic md_busy,
  output logic muldiv_start,
  output logic muldiv_abort
);

  localparam int CW = $clog2(MD_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

  hz_state_e     state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          done_seen, done_seen_next;
  logic          done_eff;

  assign done_eff = muldiv_done | done_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt       <= '0;
      done_seen <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      done_seen <= done_seen_next;
    end
  end

  // cnt holds EX cycles since the start cycle (start cycle = 0), so the
  // abort lands on cycle MD_TIMEOUT-1; a pending abort waits out a mem stall.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    done_seen_next = done_seen;
    unique case (state)
      RUN: begin
        cnt_next       = '0;
        done_seen_next = 1'b0;
        if (ex_muldiv) begin
          state_next = MD_BUSY;
          cnt_next   = CW'(1);
        end
      end
      MD_BUSY: begin
        if (done_eff) begin
          if (mem_wait) begin
            state_next     = MD_HOLD;
            done_seen_next = 1'b1;
          end else begin
            state_next = RUN;
          end
        end else if (cnt == CNT_LAST) begin
          if (!mem_wait) state_next = RUN;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      MD_HOLD: begin
        if (!mem_wait) begin
          state_next     = RUN;
          done_seen_next = 1'b0;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    md_active    = (state != RUN);
    md_busy      = 1'b0;
    muldiv_start = 1'b0;
    muldiv_abort = 1'b0;
    unique case (state)
      RUN: begin
        muldiv_start = ex_muldiv;
        md_busy      = ex_muldiv;
      end
      MD_BUSY: begin
        if (done_eff)                       md_busy      = mem_wait;
        else if (cnt == CNT_LAST && !mem_wait) muldiv_abort = 1'b1;
        else                                md_busy      = 1'b1;
      end
      MD_HOLD: md_busy = mem_wait;
      default: md_busy = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MD_TIMEOUT = 40
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W    = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              mem_wait, load_use, redirect;
  logic              md_active, md_busy, md_start, md_abort;
  hz_ctrl_t          ctrl, ctrl_out;

  assign id_rs1   = hz.ID_rs1;
  assign id_rs2   = hz.ID_rs2;
  assign ex_rd    = hz.EX_rd;
  assign mem_wait = hz.MEM_access & ~hz.dmem_ready;
  assign load_use = hz.EX_mem_read && (ex_rd != '0) &&
                    ((hz.ID_use_rs1 && id_rs1 == ex_rd) ||
                     (hz.ID_use_rs2 && id_rs2 == ex_rd));

  pipeline_hazard_ctrl_muldiv_seq #(
    .MD_TIMEOUT (MD_TIMEOUT)
  ) u_muldiv_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_muldiv    (hz.EX_muldiv),
    .muldiv_done  (hz.muldiv_done),
    .mem_wait     (mem_wait),
    .md_active    (md_active),
    .md_busy      (md_busy),
    .muldiv_start (md_start),
    .muldiv_abort (md_abort)
  );

  // Literals are {MEM,EX,ID,IF} stalls and {WB,MEM,EX,ID} flushes.
  always_comb begin
    ctrl     = HZ_NOP;
    redirect = 1'b0;
    if (mem_wait)          ctrl = hz_make(4'b1111, 4'b1000);
    else if (md_abort)     ctrl = hz_make(4'b0011, 4'b0110);
    else if (md_busy)      ctrl = hz_make(4'b0111, 4'b0100);
    else if (md_active)    ctrl = HZ_NOP;
    else if (hz.EX_pc_src) begin
      ctrl     = hz_make(4'b0000, 4'b0011);
      redirect = 1'b1;
    end
    else if (load_use)     ctrl = hz_make(4'b0011, 4'b0010);
  end

  assign ctrl_out        = rst_n ? ctrl : HZ_NOP;
  assign hz.muldiv_start = rst_n & md_start;
  assign hz.muldiv_abort = rst_n & md_abort;
  assign hz.IF_stall     = ctrl_out.stall[ST_IF];
  assign hz.ID_stall     = ctrl_out.stall[ST_ID];
  assign hz.EX_stall     = ctrl_out.stall[ST_EX];
  assign hz.MEM_stall    = ctrl_out.stall[ST_MEM];
  assign hz.ID_flush     = ctrl_out.flush[FL_ID];
  assign hz.EX_flush     = ctrl_out.flush[FL_EX];
  assign hz.MEM_flush    = ctrl_out.flush[FL_MEM];
  assign hz.WB_flush     = ctrl_out.flush[FL_WB];

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ctrl_out.stall[ST_IF] && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && flush_cnt != '1)              flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.perf_stall_cnt = stall_cnt;
  assign hz.perf_flush_cnt = flush_cnt;
`endif

endmodule
